// File: rtl/corr_pkg.sv
// ----------------------------------------------------------------------------
// corr_pkg : shared width defaults, FSM encoding and raster-order compare
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package corr_pkg;

  localparam int CORR_W_DEF  = 16;
  localparam int COORD_W_DEF = 13;

  localparam logic [1:0] c_idle     = 2'd0;
  localparam logic [1:0] c_dispatch = 2'd1;
  localparam logic [1:0] c_drain    = 2'd2;
  localparam logic [1:0] c_report   = 2'd3;

  // (ya*H+xa) < (yb*H+xb) holds exactly when this does, since x < H always.
  function automatic logic raster_before(input logic [31:0] xa, input logic [31:0] ya,
                                         input logic [31:0] xb, input logic [31:0] yb);
    return (ya < yb) || ((ya == yb) && (xa < xb));
  endfunction

endpackage

`default_nettype wire

// File: rtl/corr_dispatch_if.sv
// ----------------------------------------------------------------------------
// corr_dispatch_if : start/position/done/result bundle to the engine array
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface corr_dispatch_if
  import corr_pkg::*;
#(
  parameter int NUM_ENG = 2,
  parameter int CORR_W  = CORR_W_DEF,
  parameter int COORD_W = COORD_W_DEF
);

  logic [NUM_ENG-1:0]         start;
  logic [NUM_ENG*COORD_W-1:0] x;
  logic [NUM_ENG*COORD_W-1:0] y;
  logic [NUM_ENG-1:0]         done;
  logic [NUM_ENG*CORR_W-1:0]  corr;

  modport master (output start, x, y, input done, corr);
  modport slave  (input start, x, y, output done, corr);

endinterface

`default_nettype wire

// File: rtl/corr_peak_sel.sv
// ----------------------------------------------------------------------------
// corr_peak_sel : NUM_ENG-way max of qualified results plus the current peak,
//                 ties resolved toward the earlier raster position
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module corr_peak_sel
  import corr_pkg::*;
#(
  parameter int NUM_ENG = 2,
  parameter int CORR_W  = CORR_W_DEF,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic [NUM_ENG-1:0]         cand_vld,
  input  logic [NUM_ENG*CORR_W-1:0]  cand_corr,
  input  logic [NUM_ENG*COORD_W-1:0] cand_x,
  input  logic [NUM_ENG*COORD_W-1:0] cand_y,
  input  logic                       cur_vld,
  input  logic [CORR_W-1:0]          cur_corr,
  input  logic [COORD_W-1:0]         cur_x,
  input  logic [COORD_W-1:0]         cur_y,
  output logic [CORR_W-1:0]          win_corr,
  output logic [COORD_W-1:0]         win_x,
  output logic [COORD_W-1:0]         win_y,
  output logic                       update
);

  logic                w_best_vld;
  logic [CORR_W-1:0]   w_c;
  logic [COORD_W-1:0]  w_x;
  logic [COORD_W-1:0]  w_y;

  always_comb begin
    w_best_vld = cur_vld;
    win_corr   = cur_corr;
    win_x      = cur_x;
    win_y      = cur_y;
    update     = 1'b0;
    w_c        = '0;
    w_x        = '0;
    w_y        = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      w_c = cand_corr[i*CORR_W +: CORR_W];
      w_x = cand_x[i*COORD_W +: COORD_W];
      w_y = cand_y[i*COORD_W +: COORD_W];
      if (cand_vld[i] &&
          (!w_best_vld || (w_c > win_corr) ||
           ((w_c == win_corr) && raster_before(32'(w_x), 32'(w_y), 32'(win_x), 32'(win_y))))) begin
        w_best_vld = 1'b1;
        win_corr   = w_c;
        win_x      = w_x;
        win_y      = w_y;
        update     = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/corr_dispatch.sv
// ----------------------------------------------------------------------------
// corr_dispatch : hands raster-ordered candidates to idle engines, keeps the
//                 peak. Define CORR_THRESH_EN for iThresh qualify + oFound.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module corr_dispatch
  import corr_pkg::*;
#(
  parameter int NUM_ENG = 2,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int CORR_W  = CORR_W_DEF,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iFrameDone,
  corr_dispatch_if.master    eng,
`ifdef CORR_THRESH_EN
  input  logic [CORR_W-1:0]  iThresh,
  output logic               oFound,
`endif
  output logic               oBusy,
  output logic [COORD_W-1:0] oXresult,
  output logic [COORD_W-1:0] oYresult,
  output logic [CORR_W-1:0]  oPeakCorr,
  output logic               oResultValid
);

  localparam int                 CNT_W    = $clog2(NUM_ENG + 1);
  localparam logic [COORD_W-1:0] c_x_last = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] c_y_last = COORD_W'(V_RES - 1);

  logic [1:0]                 r_state;
  logic [NUM_ENG-1:0]         r_idle;
  logic [NUM_ENG-1:0]         r_start;
  logic [NUM_ENG*COORD_W-1:0] r_x;
  logic [NUM_ENG*COORD_W-1:0] r_y;
  logic [COORD_W-1:0]         r_pos_x;
  logic [COORD_W-1:0]         r_pos_y;
  logic [CNT_W-1:0]           r_out;
  logic                       r_peak_vld;
  logic [CORR_W-1:0]          r_peak_corr;
  logic [COORD_W-1:0]         r_peak_x;
  logic [COORD_W-1:0]         r_peak_y;

  logic [NUM_ENG-1:0] w_acc;
  logic [NUM_ENG-1:0] w_free;
  logic [NUM_ENG-1:0] w_pass;
  logic [NUM_ENG-1:0] w_cand;
  logic [NUM_ENG-1:0] w_grant;
  logic               w_launch;
  logic               w_disp_en;
  logic               w_disp;
  logic               w_last;
  logic [COORD_W-1:0] w_cur_x;
  logic [COORD_W-1:0] w_cur_y;
  logic [CNT_W-1:0]   w_n_acc;
  logic [CORR_W-1:0]  w_win_corr;
  logic [COORD_W-1:0] w_win_x;
  logic [COORD_W-1:0] w_win_y;
  logic               w_upd;

  // Done from an engine we never started is dropped here and nowhere else.
  assign w_acc  = eng.done & ~r_idle;
  assign w_free = r_idle | w_acc;

  // Dispatch decisions are registered, so the launch edge itself issues (0,0).
  assign w_launch  = (r_state == c_idle) && iFrameDone;
  assign w_disp_en = w_launch || (r_state == c_dispatch);
  assign w_cur_x   = w_launch ? '0 : r_pos_x;
  assign w_cur_y   = w_launch ? '0 : r_pos_y;
  assign w_last    = (w_cur_x == c_x_last) && (w_cur_y == c_y_last);
  assign w_disp    = |w_grant;

  always_comb begin
    w_grant = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (w_disp_en && w_free[i] && (w_grant == '0)) w_grant[i] = 1'b1;
    end
  end

  always_comb begin
    w_n_acc = '0;
    for (int i = 0; i < NUM_ENG; i++) w_n_acc = w_n_acc + CNT_W'(w_acc[i]);
  end

`ifdef CORR_THRESH_EN
  always_comb begin
    w_pass = '0;
    for (int i = 0; i < NUM_ENG; i++) w_pass[i] = (eng.corr[i*CORR_W +: CORR_W] >= iThresh);
  end
`else
  assign w_pass = '1;
`endif

  assign w_cand = w_acc & w_pass;

  corr_peak_sel #(
    .NUM_ENG (NUM_ENG),
    .CORR_W  (CORR_W),
    .COORD_W (COORD_W)
  ) u_peak_sel (
    .cand_vld  (w_cand),
    .cand_corr (eng.corr),
    .cand_x    (r_x),
    .cand_y    (r_y),
    .cur_vld   (r_peak_vld),
    .cur_corr  (r_peak_corr),
    .cur_x     (r_peak_x),
    .cur_y     (r_peak_y),
    .win_corr  (w_win_corr),
    .win_x     (w_win_x),
    .win_y     (w_win_y),
    .update    (w_upd)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state     <= c_idle;
      r_idle      <= '1;
      r_start     <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_pos_x     <= '0;
      r_pos_y     <= '0;
      r_out       <= '0;
      r_peak_vld  <= 1'b0;
      r_peak_corr <= '0;
      r_peak_x    <= '0;
      r_peak_y    <= '0;
    end else begin
      r_start <= w_grant;
      r_idle  <= w_free & ~w_grant;
      r_out   <= r_out + CNT_W'(w_disp) - w_n_acc;

      for (int i = 0; i < NUM_ENG; i++) begin
        if (w_grant[i]) begin
          r_x[i*COORD_W +: COORD_W] <= w_cur_x;
          r_y[i*COORD_W +: COORD_W] <= w_cur_y;
        end
      end

      if (w_launch) begin
        r_pos_x <= '0;
        r_pos_y <= '0;
      end
      if (w_disp && !w_last) begin
        if (w_cur_x == c_x_last) begin
          r_pos_x <= '0;
          r_pos_y <= w_cur_y + 1'b1;
        end else begin
          r_pos_x <= w_cur_x + 1'b1;
          r_pos_y <= w_cur_y;
        end
      end

      if (w_launch) begin
        r_peak_vld  <= 1'b0;
        r_peak_corr <= '0;
        r_peak_x    <= '0;
        r_peak_y    <= '0;
      end else if (w_upd) begin
        r_peak_vld  <= 1'b1;
        r_peak_corr <= w_win_corr;
        r_peak_x    <= w_win_x;
        r_peak_y    <= w_win_y;
      end

      case (r_state)
        c_idle:     if (w_launch) r_state <= w_last ? c_drain : c_dispatch;
        c_dispatch: if (w_disp && w_last) r_state <= c_drain;
        c_drain:    if (r_out == '0) r_state <= c_report;
        c_report:   r_state <= c_idle;
        default:    r_state <= c_idle;
      endcase
    end
  end

`ifdef CORR_THRESH_EN
  // The peak only ever loads from qualifying results, so its valid bit is the answer.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oFound <= 1'b0;
    end else if (w_launch) begin
      oFound <= 1'b0;
    end else if ((r_state == c_drain) && (r_out == '0)) begin
      oFound <= r_peak_vld;
    end
  end
`endif

  assign eng.start    = r_start;
  assign eng.x        = r_x;
  assign eng.y        = r_y;
  assign oBusy        = (r_state == c_dispatch) || (r_state == c_drain);
  assign oResultValid = (r_state == c_report);
  assign oXresult     = r_peak_x;
  assign oYresult     = r_peak_y;
  assign oPeakCorr    = r_peak_corr;

endmodule

`default_nettype wire
